// File: rtl/fifo_upsize_pkg.sv
// Shared helpers for the narrow-to-wide packing FIFO.
package fifo_upsize_pkg;

  // Lane that beat k of a word lands in. The mapping is its own inverse,
  // so it also gives the beat index that fills a given lane.
  function automatic int lane_of(input int k, input int ratio, input bit first_msb);
    return first_msb ? (ratio - 1 - k) : k;
  endfunction

endpackage

// File: rtl/fifo_sync_wide.sv
// Generic synchronous FIFO with level output. A push into a full queue is
// accepted when a pop happens on the same edge.
module fifo_sync_wide #(
  parameter int W     = 72,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wr_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [LW-1:0] level_reg;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (level_reg != '0);
  assign do_push = push && ((level_reg < DEPTH_L) || do_pop);
  assign valid   = (level_reg != '0);
  assign level   = level_reg;

  // Occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= '0;
    end else if (do_push && !do_pop) begin
      level_reg <= level_reg + 1'b1;
    end else if (do_pop && !do_push) begin
      level_reg <= level_reg - 1'b1;
    end
  end

  generate
    if (DEPTH == 1) begin : g_single
      logic [W-1:0] entry_reg;

      // Single entry; occupancy bit above doubles as its valid flag.
      always_ff @(posedge clk) begin
        if (do_push) begin
          entry_reg <= wr_data;
        end
      end

      assign rd_data = entry_reg;
    end else begin : g_ring
      localparam int PW = $clog2(DEPTH);
      logic [W-1:0]  mem [DEPTH];
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;

      // Storage array, written at the tail; no reset needed on contents.
      always_ff @(posedge clk) begin
        if (do_push) begin
          mem[wr_ptr_reg] <= wr_data;
        end
      end

      // Ring pointers wrap naturally since DEPTH is a power of two.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

      // Head is presented directly so b_valid and b_data line up.
      assign rd_data = mem[rd_ptr_reg];
    end
  endgenerate

endmodule

// File: rtl/fifo_upsize.sv
// Narrow-to-wide packer: gathers RATIO beats into one wide word, queues
// completed words, and can flush a partial word with a lane mask.
module fifo_upsize
  import fifo_upsize_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 2,
  parameter int FIRST_MSB = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_W-1:0]            a_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic                       flush,
  output logic [IN_W*RATIO-1:0]      b_data,
  output logic [RATIO-1:0]           b_mask,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO + 1);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST    = CW'(RATIO - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [CW-1:0]    count_reg, count_next, count_after;
  logic [OUT_W-1:0] asm_reg, asm_next, asm_merged;
  logic [RATIO-1:0] mask_reg, mask_next, mask_merged;
  logic             flush_pend_reg, flush_pend_next;
  logic             space, beat_acc, want_flush, push, pop;

  assign pop         = b_valid && b_ready;
  assign space       = (level < DEPTH_L) || pop;
  assign a_ready     = !flush_pend_reg && ((count_reg < LAST) || space);
  assign beat_acc    = a_valid && a_ready;
  assign count_after = count_reg + {{(CW-1){1'b0}}, beat_acc};
  // A flush while one is already pending is absorbed.
  assign want_flush  = flush && !flush_pend_reg && (count_after != '0);
  assign push        = (beat_acc && (count_reg == LAST))
                    || (flush_pend_reg && space)
                    || (want_flush && space);

  // Assembly register with the beat accepted this cycle merged in, so a
  // flush in the same cycle includes it.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      localparam logic [CW-1:0] BEAT = CW'(lane_of(gi, RATIO, FIRST_MSB != 0));
      logic hit;
      assign hit = beat_acc && (count_reg == BEAT);
      assign asm_merged[gi*IN_W +: IN_W] = hit ? a_data : asm_reg[gi*IN_W +: IN_W];
      assign mask_merged[gi]             = hit | mask_reg[gi];
    end
  endgenerate

  // Next-state for beat count, assembly lanes and pending flush.
  always_comb begin
    count_next      = count_reg;
    asm_next        = asm_reg;
    mask_next       = mask_reg;
    flush_pend_next = flush_pend_reg;
    if (push) begin
      count_next      = '0;
      asm_next        = '0;
      mask_next       = '0;
      flush_pend_next = 1'b0;
    end else begin
      if (beat_acc) begin
        count_next = count_after;
        asm_next   = asm_merged;
        mask_next  = mask_merged;
      end
      if (want_flush) begin
        flush_pend_next = 1'b1;
      end
    end
  end

  // Packer state registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg      <= '0;
      asm_reg        <= '0;
      mask_reg       <= '0;
      flush_pend_reg <= 1'b0;
    end else begin
      count_reg      <= count_next;
      asm_reg        <= asm_next;
      mask_reg       <= mask_next;
      flush_pend_reg <= flush_pend_next;
    end
  end

  fifo_sync_wide #(
    .W     (OUT_W + RATIO),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({mask_merged, asm_merged}),
    .pop     (pop),
    .rd_data ({b_mask, b_data}),
    .valid   (b_valid),
    .level   (level)
  );

endmodule
